// File: rtl/sample_capture.sv
// sample_capture: SDR/DDR pad sampler with per-bit glitch filter, programmable
// sample divider and a valid/ready output stage with a sticky overrun flag.
module sample_capture #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] indata,
    input  logic [WIDTH-1:0] indata180,
    input  logic             enable,
    input  logic             falling_edge,
    input  logic             demux_mode,
    input  logic             filter_mode,
    input  logic [23:0]      divider,
    input  logic             sample_ready,
    input  logic             clear_overrun,
    output logic             sample_valid,
    output logic [WIDTH-1:0] sample_data,
    output logic             overrun
);
    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] r_s1, r_s1_prev, r_filt, r_data;
    logic [23:0]      r_cnt;
    logic             r_valid, r_overrun;
    logic [WIDTH-1:0] w_sel, w_stable, w_filt_next, w_word;
    logic             w_tick, w_load, w_drop;

    assign w_sel       = demux_mode ? {indata180[WIDTH-H-1:0], indata[H-1:0]}
                                    : (falling_edge ? indata180 : indata);
    // A bit only moves once it has been seen at the same level on two clocks.
    assign w_stable    = ~(r_s1 ^ r_s1_prev);
    assign w_filt_next = (r_s1 & w_stable) | (r_filt & ~w_stable);
    assign w_word      = filter_mode ? w_filt_next : r_s1;
    assign w_tick      = enable && (r_cnt == '0);
    assign w_load      = w_tick && (!r_valid || sample_ready);
    assign w_drop      = w_tick && r_valid && !sample_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1      <= '0;
            r_s1_prev <= '0;
            r_filt    <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_s1      <= w_sel;
            r_s1_prev <= r_s1;
            r_filt    <= w_filt_next;
            r_cnt     <= !enable ? '0 : (w_tick ? divider : r_cnt - 24'd1);
            if (w_load)
                r_data <= w_word;
            r_valid   <= w_tick || (r_valid && !sample_ready);
            r_overrun <= w_drop || (r_overrun && !clear_overrun);
        end
    end

    assign sample_valid = r_valid;
    assign sample_data  = r_data;
    assign overrun      = r_overrun;
endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: table vectors, directed corner sequences and randomized
// traffic checked every cycle against a behavioural model.
module tb_sample_capture;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] indata = '0, indata180 = '0;
    logic        enable = 1'b0, falling_edge = 1'b0, demux_mode = 1'b0, filter_mode = 1'b0;
    logic [23:0] divider = '0;
    logic        sample_ready = 1'b0, clear_overrun = 1'b0;
    logic        sample_valid, overrun;
    logic [31:0] sample_data;

    always #5 clk = ~clk;

    sample_capture #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .indata(indata), .indata180(indata180),
        .enable(enable), .falling_edge(falling_edge), .demux_mode(demux_mode),
        .filter_mode(filter_mode), .divider(divider), .sample_ready(sample_ready),
        .clear_overrun(clear_overrun), .sample_valid(sample_valid),
        .sample_data(sample_data), .overrun(overrun)
    );

    int n_cmp = 0, n_bad = 0;

    // Model: history of selected words, tick spacing from the divider seen at
    // the last tick, and the output register contents.
    logic [31:0] hist[$];
    int          cyc, last_tick, last_per;
    bit          active;
    logic        m_valid, m_ovr;
    logic [31:0] m_data;

    typedef struct {
        logic [31:0] d;
        logic [31:0] d180;
        logic        fe;
        logic        dm;
        logic [31:0] exp;
    } vec_t;
    vec_t        vecs[6];
    logic [31:0] seq_in[10], seq_exp[10];
    logic [8:0]  tick_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(32'h0);
        hist.push_back(32'h0);
        active = 0; cyc = 0; last_tick = 0; last_per = 0;
        m_valid = 1'b0; m_data = '0; m_ovr = 1'b0;
    endtask

    // Each bit takes the value it last held on two consecutive clocks.
    function automatic logic [31:0] filt_of();
        logic [31:0] r = '0;
        for (int b = 0; b < 32; b++) begin
            bit found = 0;
            for (int k = hist.size() - 1; k >= 1 && !found; k--)
                if (hist[k][b] == hist[k-1][b]) begin
                    r[b] = hist[k][b];
                    found = 1;
                end
        end
        return r;
    endfunction

    task automatic model_edge();
        logic [31:0] sel, word;
        logic        tick, drop;
        sel  = demux_mode ? {indata180[15:0], indata[15:0]} : (falling_edge ? indata180 : indata);
        word = filter_mode ? filt_of() : hist[hist.size()-1];
        tick = enable && (!active || (cyc - last_tick == last_per + 1));
        if (tick) begin
            last_tick = cyc;
            last_per  = int'(divider);
        end
        active = enable;
        drop = 1'b0;
        if (tick) begin
            if (!m_valid || sample_ready) begin
                m_data  = word;
                m_valid = 1'b1;
            end else drop = 1'b1;
        end else if (m_valid && sample_ready) m_valid = 1'b0;
        m_ovr = drop | (m_ovr & ~clear_overrun);
        hist.push_back(sel);
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_valid", {31'b0, sample_valid}, {31'b0, m_valid});
        chk("model_data", sample_data, m_data);
        chk("model_ovr", {31'b0, overrun}, {31'b0, m_ovr});
    endtask

    task automatic async_reset_check(input string tag);
        reset_n = 1'b0;
        #2;
        chk({tag, "_valid"}, {31'b0, sample_valid}, 32'h0);
        chk({tag, "_data"}, sample_data, 32'h0);
        chk({tag, "_ovr"}, {31'b0, overrun}, 32'h0);
        model_reset();
        #2 reset_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001};
        vecs[1] = '{32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0002};
        vecs[2] = '{32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{32'hAAAA_1234, 32'h5555_ABCD, 1'b0, 1'b1, 32'hABCD_1234};
        vecs[4] = '{32'hAAAA_1234, 32'h5555_ABCD, 1'b1, 1'b1, 32'hABCD_1234};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF};
        seq_in  = '{32'h1, 32'h0, 32'h0, 32'h2, 32'h2, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0};
        seq_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h2, 32'h2, 32'h0, 32'h0};
        tick_mask = 9'b1_0101_0001;

        model_reset();
        #1 async_reset_check("reset");
        reset_n = 1'b0;
        #17 reset_n = 1'b1;

        // Mode selection table, divider 0, consumer always ready
        divider = '0; sample_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            indata = vecs[i].d; indata180 = vecs[i].d180;
            falling_edge = vecs[i].fe; demux_mode = vecs[i].dm;
            step(); step();
            chk("vec_data", sample_data, vecs[i].exp);
            chk("vec_valid", {31'b0, sample_valid}, 32'h1);
        end
        falling_edge = 1'b0; demux_mode = 1'b0;

        // Back-to-back words appear two clocks later with valid held high
        for (int i = 0; i < 5; i++) begin
            indata = (i < 3) ? 32'(i + 1) : 32'h0;
            step();
            chk("v1_valid", {31'b0, sample_valid}, 32'h1);
            if (i >= 1 && i <= 3) chk("v1_data", sample_data, 32'(i));
        end

        // Divider 3, changed to 1 after the first tick
        enable = 1'b0; step();
        divider = 24'd3; enable = 1'b1;
        for (int e = 0; e < 9; e++) begin
            step();
            if (e == 0) divider = 24'd1;
            chk("v4_tick", {31'b0, sample_valid}, {31'b0, tick_mask[e]});
        end

        // Glitch filter: 1-clk pulse on bit 0 suppressed, 3-clk pulse on bit 1 delayed
        enable = 1'b0; divider = '0; indata = '0; filter_mode = 1'b1;
        step(); step(); step();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            indata = seq_in[i];
            step();
            chk("v3_filt", sample_data, seq_exp[i]);
        end

        // Backpressure, overrun set-wins, clear, then async reset while valid
        enable = 1'b0; filter_mode = 1'b0; indata = 32'h1234_5678;
        step(); step();
        sample_ready = 1'b0; enable = 1'b1;
        step();
        chk("v5_data0", sample_data, 32'h1234_5678);
        chk("v5_ovr0", {31'b0, overrun}, 32'h0);
        indata = 32'h9ABC_DEF0;
        step();
        chk("v5_ovr1", {31'b0, overrun}, 32'h1);
        chk("v5_hold1", sample_data, 32'h1234_5678);
        clear_overrun = 1'b1;
        step();
        chk("v5_setwins", {31'b0, overrun}, 32'h1);
        chk("v5_hold2", sample_data, 32'h1234_5678);
        enable = 1'b0;
        step();
        chk("v5_cleared", {31'b0, overrun}, 32'h0);
        chk("v5_pending", {31'b0, sample_valid}, 32'h1);
        clear_overrun = 1'b0;
        async_reset_check("v6");
        step(); step();

        // Randomized traffic; modes only change while disabled
        for (int b = 0; b < 20; b++) begin
            enable = 1'b0;
            falling_edge = 1'($urandom); demux_mode = 1'($urandom); filter_mode = 1'($urandom);
            step(); step();
            enable = 1'b1;
            for (int c = 0; c < 30; c++) begin
                indata = $urandom; indata180 = $urandom;
                sample_ready  = ($urandom_range(3) != 0);
                clear_overrun = ($urandom_range(7) == 0);
                if ($urandom_range(9) == 0) divider = 24'($urandom_range(4));
                if ($urandom_range(19) == 0) enable = ~enable;
                if (c == 15 && b % 5 == 4) async_reset_check("rand_rst");
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
